// File: rtl/st_req_queue.sv
// Store-request FIFO between LSU issue and the store unit; oldest entry is presented at the head.
// Optional macro ST_REQ_QUEUE_FALLTHROUGH_EN lets a request bypass an empty queue combinationally.

package st_req_queue_pkg;

    typedef enum logic [3:0] {
        OP_SB      = 4'd0,
        OP_SH      = 4'd1,
        OP_SW      = 4'd2,
        OP_SD      = 4'd3,
        OP_AMO_ADD = 4'd4,
        OP_AMO_SWP = 4'd5
    } st_op_e;

    typedef struct packed {
        logic [31:0] vaddr;
        logic [31:0] data;
        logic [3:0]  be;
        st_op_e      operation;
        logic [3:0]  trans_id;
    } lsu_ctrl_t;

endpackage

module st_req_queue
    import st_req_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    input  lsu_ctrl_t        lsu_ctrl_i,
    output logic             ready_o,
    input  logic             pop_i,
    output logic             valid_o,
    output lsu_ctrl_t        lsu_ctrl_o,
    output logic [PTR_W:0]   usage_o,
    output logic             empty_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    lsu_ctrl_t        mem_q [DEPTH];
    lsu_ctrl_t        mem_d [DEPTH];

    logic bypass;
    logic push;
    logic pop;

    // ready_o looks only at the registered count, so a same-cycle pop never frees a slot.
    assign ready_o = (count_q != FULL_CNT);
    assign empty_o = (count_q == '0);
    assign usage_o = count_q;

    always_comb begin
        bypass     = 1'b0;
        valid_o    = (count_q != '0);
        lsu_ctrl_o = mem_q[rd_ptr_q];
`ifdef ST_REQ_QUEUE_FALLTHROUGH_EN
        // An empty queue forwards the incoming request; if popped now it is never stored.
        if (count_q == '0 && valid_i && !flush_i) begin
            valid_o    = 1'b1;
            lsu_ctrl_o = lsu_ctrl_i;
            bypass     = pop_i;
        end
`endif
    end

    assign push = valid_i && ready_o && !bypass;
    assign pop  = pop_i && valid_o && !bypass;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = lsu_ctrl_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: payload storage is left unreset; the count qualifies it, and skipping reset keeps it plain RAM.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && count_q == FULL_CNT))
        else $error("st_req_queue: push accepted while full");
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && count_q == '0))
        else $error("st_req_queue: pop taken while empty");
    assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= FULL_CNT)
        else $error("st_req_queue: count exceeds depth");
`endif

endmodule

// File: tb/tb_st_req_queue.sv
// Directed, table-driven bench for st_req_queue (DEPTH=4), plus wrap and fall-through sequences.

module tb_st_req_queue;
    import st_req_queue_pkg::*;

    localparam int DEPTH = 4;

    logic      clk_i = 1'b0;
    logic      rst_ni = 1'b0;
    logic      flush_i = 1'b0;
    logic      valid_i = 1'b0;
    lsu_ctrl_t lsu_ctrl_i;
    logic      ready_o;
    logic      pop_i = 1'b0;
    logic      valid_o;
    lsu_ctrl_t lsu_ctrl_o;
    logic [2:0] usage_o;
    logic      empty_o;

    int n_checks = 0;
    int n_errors = 0;

    st_req_queue #(.DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .lsu_ctrl_i (lsu_ctrl_i),
        .ready_o    (ready_o),
        .pop_i      (pop_i),
        .valid_o    (valid_o),
        .lsu_ctrl_o (lsu_ctrl_o),
        .usage_o    (usage_o),
        .empty_o    (empty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       flush;
        logic       valid;
        logic [3:0] tid;
        logic       pop;
        logic       e_valid;
        logic [3:0] e_tid;
        logic [2:0] e_usage;
        logic       e_ready;
        logic       e_empty;
    } vec_t;

    function automatic lsu_ctrl_t mk(input logic [3:0] tid);
        lsu_ctrl_t r;
        r.vaddr     = 32'h8000_0000 + {24'h0, tid, 4'h0};
        r.data      = {8{tid}};
        r.be        = 4'hf;
        r.operation = OP_SW;
        r.trans_id  = tid;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic ev, input logic [3:0] et,
                              input logic [2:0] eu, input logic er, input logic ee);
        check({name, ".valid"}, 128'(valid_o), 128'(ev));
        check({name, ".usage"}, 128'(usage_o), 128'(eu));
        check({name, ".ready"}, 128'(ready_o), 128'(er));
        check({name, ".empty"}, 128'(empty_o), 128'(ee));
        if (ev) check({name, ".head"}, 128'(lsu_ctrl_o), 128'(mk(et)));
    endtask

    // Drive inputs shortly after an edge, then sample combinational outputs before the next edge.
    task automatic drive(input logic fl, input logic vl, input logic [3:0] tid, input logic pp);
        flush_i    = fl;
        valid_i    = vl;
        lsu_ctrl_i = mk(tid);
        pop_i      = pp;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    vec_t vecs [19];

    initial begin
        logic       ev;
        logic [3:0] et;

        //         flush valid tid  pop  | valid tid usage ready empty  (outputs before the edge)
        vecs[0]  = '{1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 4'd0,  3'd0, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 4'd2,  1'b0, 1'b1, 4'd1,  3'd1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 4'd3,  1'b0, 1'b1, 4'd1,  3'd2, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd1,  3'd3, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 4'd4,  1'b0, 1'b1, 4'd1,  3'd3, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 4'd1,  3'd4, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd2,  3'd3, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd2,  3'd3, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd3,  3'd2, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd4,  3'd1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  3'd0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 4'd10, 1'b0, 1'b0, 4'd0,  3'd0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 4'd11, 1'b0, 1'b1, 4'd10, 3'd1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 4'd12, 1'b0, 1'b1, 4'd10, 3'd2, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  3'd0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  3'd0, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  3'd0, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  3'd0, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  3'd0, 1'b1, 1'b1};

        lsu_ctrl_i = mk(4'd0);
        repeat (2) @(negedge clk_i);
        check_outs("reset", 1'b0, 4'd0, 3'd0, 1'b1, 1'b1);
        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].flush, vecs[i].valid, vecs[i].tid, vecs[i].pop);
            ev = vecs[i].e_valid;
            et = vecs[i].e_tid;
`ifdef ST_REQ_QUEUE_FALLTHROUGH_EN
            if (vecs[i].e_usage == 3'd0 && vecs[i].valid && !vecs[i].flush) begin
                ev = 1'b1;
                et = vecs[i].tid;
            end
`endif
            check_outs($sformatf("vec%0d", i), ev, et, vecs[i].e_usage, vecs[i].e_ready, vecs[i].e_empty);
            tick();
        end

        // Continuous push+pop across pointer wrap: head order 0..9, occupancy steady at 1.
        drive(1'b0, 1'b1, 4'd0, 1'b0);
`ifdef ST_REQ_QUEUE_FALLTHROUGH_EN
        check_outs("wrap_fill", 1'b1, 4'd0, 3'd0, 1'b1, 1'b1);
`else
        check_outs("wrap_fill", 1'b0, 4'd0, 3'd0, 1'b1, 1'b1);
`endif
        tick();
        for (int i = 1; i < 10; i++) begin
            drive(1'b0, 1'b1, 4'(i), 1'b1);
            check_outs($sformatf("wrap%0d", i), 1'b1, 4'(i - 1), 3'd1, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        check_outs("wrap_last", 1'b1, 4'd9, 3'd1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'd0, 1'b0);
        check_outs("wrap_done", 1'b0, 4'd0, 3'd0, 1'b1, 1'b1);
        tick();

        // Push and pop on an empty queue in the same cycle.
        drive(1'b0, 1'b1, 4'd7, 1'b1);
`ifdef ST_REQ_QUEUE_FALLTHROUGH_EN
        check_outs("ft_same", 1'b1, 4'd7, 3'd0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'd0, 1'b0);
        check_outs("ft_after", 1'b0, 4'd0, 3'd0, 1'b1, 1'b1);
        tick();
`else
        check_outs("ft_same", 1'b0, 4'd0, 3'd0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        check_outs("ft_after", 1'b1, 4'd7, 3'd1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'd0, 1'b0);
        check_outs("ft_drained", 1'b0, 4'd0, 3'd0, 1'b1, 1'b1);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
